accel_req_arbiter: RTL and testbench

Round-robin arbiter that shares Ara's single accelerator request/response port between `NrReq` instruction sources, such as several trace dispatchers or a CVA6 front-end plus a trace injector. It forwards one vector instruction (`insn`, `rs1`, `rs2`) per handshake to Ara. It records the issuing requester in an in-order ID FIFO and routes each Ara response back to that requester. It sits between the instruction sources and `i_system.i_ara`'s accelerator interface.

---
 rtl/ara_pkg.sv | 14 +
 rtl/accel_arb_id_fifo.sv | 52 +++++
 rtl/accel_req_arbiter.sv | 137 +++++++++++++
 tb/tb_accel_req_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_pkg.sv
// ara_pkg: shared types and constants for the accelerator request arbiter.
// Payload operand fields are AccArbXlen wide; the arbiter supports XLEN up to that width.
package ara_pkg;

    localparam int unsigned AccArbCntWidth = 32;
    localparam int unsigned AccArbXlen     = 64;

    typedef struct packed {
        logic [31:0]           insn;
        logic [AccArbXlen-1:0] rs1;
        logic [AccArbXlen-1:0] rs2;
    } acc_arb_payload_t;

endpackage

// File: rtl/accel_arb_id_fifo.sv
// accel_arb_id_fifo: in-order requester-ID FIFO, flop based, no fall-through.
// Pointers wrap naturally; the count is one bit wider so full and empty are distinct.
module accel_arb_id_fifo #(
    parameter int unsigned IdWidth = 1,
    parameter int unsigned Depth   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [IdWidth-1:0] id_i,
    output logic [IdWidth-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [IdWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PtrW:0]      cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign full_o  = cnt_q == (PtrW+1)'(Depth);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = do_push ? wr_q + PtrW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + PtrW'(1) : rd_q;
        cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= id_i;
    end

endmodule

// File: rtl/accel_req_arbiter.sv
// accel_req_arbiter: round-robin share of Ara's accelerator port with in-order response routing.
// Define ACC_ARB_PERF_EN to build saturating per-requester grant counters.
module accel_req_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NrReq          = 2,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned XLEN           = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NrReq-1:0]                     req_valid_i,
    output logic [NrReq-1:0]                     req_ready_o,
    input  logic [NrReq-1:0][31:0]               req_insn_i,
    input  logic [NrReq-1:0][XLEN-1:0]           req_rs1_i,
    input  logic [NrReq-1:0][XLEN-1:0]           req_rs2_i,
    output logic [NrReq-1:0]                     resp_valid_o,
    input  logic [NrReq-1:0]                     resp_ready_i,
    output logic [XLEN-1:0]                      resp_result_o,
    output logic                                 resp_error_o,
    output logic                                 acc_req_valid_o,
    input  logic                                 acc_req_ready_i,
    output logic [31:0]                          acc_insn_o,
    output logic [XLEN-1:0]                      acc_rs1_o,
    output logic [XLEN-1:0]                      acc_rs2_o,
    input  logic                                 acc_resp_valid_i,
    output logic                                 acc_resp_ready_o,
    input  logic [XLEN-1:0]                      acc_resp_result_i,
    input  logic                                 acc_resp_error_i,
    output logic [NrReq-1:0][AccArbCntWidth-1:0] perf_grant_cnt_o
);

    localparam int unsigned IdW = $clog2(NrReq);
    typedef logic [IdW-1:0] id_t;

    id_t prio_q, prio_d, lock_id_q, lock_id_d, grant, rr_pick, idx, head;
    logic lock_q, lock_d, found, full, empty, push, pop, spurious;
    acc_arb_payload_t [NrReq-1:0] payload;
    acc_arb_payload_t sel;

    always_comb begin
        rr_pick = prio_q;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            idx = id_t'((32'(prio_q) + i) % NrReq);
            if (!found && req_valid_i[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        payload = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            payload[i].insn = req_insn_i[i];
            payload[i].rs1  = AccArbXlen'(req_rs1_i[i]);
            payload[i].rs2  = AccArbXlen'(req_rs2_i[i]);
        end
    end

    // A locked grant overrides the round-robin pick until Ara accepts it.
    assign grant           = lock_q ? lock_id_q : rr_pick;
    assign sel             = payload[grant];
    assign acc_req_valid_o = !full && req_valid_i[grant];
    assign acc_insn_o      = sel.insn;
    assign acc_rs1_o       = XLEN'(sel.rs1);
    assign acc_rs2_o       = XLEN'(sel.rs2);
    assign req_ready_o     = (acc_req_ready_i && !full) ? NrReq'(1) << grant : '0;
    assign push            = acc_req_valid_o && acc_req_ready_i;

    always_comb begin
        lock_d    = push ? 1'b0 : acc_req_valid_o;
        lock_id_d = grant;
        prio_d    = push ? id_t'((32'(grant) + 32'd1) % NrReq) : prio_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    accel_arb_id_fifo #(
        .IdWidth (IdW),
        .Depth   (MaxOutstanding)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .id_i    (grant),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // With nothing outstanding a response is accepted and discarded.
    assign spurious         = acc_resp_valid_i && empty;
    assign resp_valid_o     = (acc_resp_valid_i && !empty) ? NrReq'(1) << head : '0;
    assign acc_resp_ready_o = empty ? acc_resp_valid_i : resp_ready_i[head];
    assign pop              = acc_resp_valid_i && !empty && resp_ready_i[head];
    assign resp_result_o    = acc_resp_result_i;
    assign resp_error_o     = acc_resp_error_i;

`ifdef ACC_ARB_PERF_EN
    logic [NrReq-1:0][AccArbCntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push && cnt_q[grant] != '1) cnt_d[grant] = cnt_q[grant] + AccArbCntWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign perf_grant_cnt_o = cnt_q;
`else
    assign perf_grant_cnt_o = '0;
`endif

    lock_drop: assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> req_valid_i[lock_id_q])
        else $error("lock_drop: requester %0d withdrew valid before acceptance", lock_id_q);

    spurious_resp: assert property (@(posedge clk_i) disable iff (!rst_ni) !spurious)
        else $warning("spurious_resp: response dropped with no outstanding request");

endmodule

// File: tb/tb_accel_req_arbiter.sv
// tb_accel_req_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_accel_req_arbiter;

    localparam logic [31:0] I0 = 32'h1111_0057;
    localparam logic [31:0] I1 = 32'h2222_0057;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
    logic [1:0][31:0] req_insn, perf;
    logic [1:0][63:0] req_rs1, req_rs2;
    logic [63:0] resp_result, acc_rs1, acc_rs2, acc_res;
    logic resp_error, acc_req_valid, acc_req_ready, acc_resp_valid, acc_resp_ready, acc_err;
    logic [31:0] acc_insn;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    accel_req_arbiter #(.NrReq(2), .MaxOutstanding(8), .XLEN(64)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_insn_i        (req_insn),
        .req_rs1_i         (req_rs1),
        .req_rs2_i         (req_rs2),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_result_o     (resp_result),
        .resp_error_o      (resp_error),
        .acc_req_valid_o   (acc_req_valid),
        .acc_req_ready_i   (acc_req_ready),
        .acc_insn_o        (acc_insn),
        .acc_rs1_o         (acc_rs1),
        .acc_rs2_o         (acc_rs2),
        .acc_resp_valid_i  (acc_resp_valid),
        .acc_resp_ready_o  (acc_resp_ready),
        .acc_resp_result_i (acc_res),
        .acc_resp_error_i  (acc_err),
        .perf_grant_cnt_o  (perf)
    );

    typedef struct {
        logic [1:0]  v;
        logic        ar;
        logic        rv;
        logic [1:0]  rr;
        logic [63:0] res;
        logic        av;
        logic [1:0]  rdy;
        logic [31:0] insn;
        logic [1:0]  rvld;
        logic        arr;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic [1:0] v, logic ar, logic rv, logic [1:0] rr, logic [63:0] res,
                                logic av, logic [1:0] rdy, logic [31:0] insn, logic [1:0] rvld, logic arr);
        vec_t t;
        t.v = v; t.ar = ar; t.rv = rv; t.rr = rr; t.res = res;
        t.av = av; t.rdy = rdy; t.insn = insn; t.rvld = rvld; t.arr = arr;
        return t;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic ar, input logic rv, input logic [1:0] rr, input logic [63:0] res);
        @(negedge clk);
        req_valid = v; acc_req_ready = ar; acc_resp_valid = rv; resp_ready = rr;
        acc_res = res; acc_err = res[0];
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 1'b0, 1'b0, 2'b00, 64'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; acc_req_ready = 1'b0; acc_resp_valid = 1'b0; resp_ready = '0;
        acc_res = '0; acc_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic req_chk(input string n, input logic av, input logic [1:0] rdy, input logic [31:0] insn);
        chk({n, " acc_valid"}, 64'(acc_req_valid), 64'(av));
        chk({n, " req_ready"}, 64'(req_ready), 64'(rdy));
        chk({n, " insn"}, 64'(acc_insn), 64'(insn));
    endtask

    task automatic rsp_chk(input string n, input logic [1:0] rvld, input logic arr);
        chk({n, " resp_valid"}, 64'(resp_valid), 64'(rvld));
        chk({n, " acc_resp_ready"}, 64'(acc_resp_ready), 64'(arr));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_perf;
        req_insn[0] = I0; req_insn[1] = I1;
        req_rs1[0] = 64'h10; req_rs1[1] = 64'h11;
        req_rs2[0] = 64'h20; req_rs2[1] = 64'h21;
`ifdef ACC_ARB_PERF_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        tbl[0]  = mk(2'b00, 0, 0, 2'b00, 64'h0,  0, 2'b00, I0, 2'b00, 0);
        for (int i = 1; i <= 4; i++)
            tbl[i] = mk(2'b01, 1, 0, 2'b00, 64'h0, 1, 2'b01, I0, 2'b00, 0);
        tbl[5]  = mk(2'b00, 0, 1, 2'b01, 64'h5,  0, 2'b00, I1, 2'b01, 1);
        tbl[6]  = mk(2'b00, 0, 1, 2'b00, 64'h6,  0, 2'b00, I1, 2'b01, 0);
        for (int i = 7; i <= 9; i++)
            tbl[i] = mk(2'b00, 0, 1, 2'b11, 64'(i), 0, 2'b00, I1, 2'b01, 1);
        tbl[10] = mk(2'b11, 1, 0, 2'b00, 64'h0,  1, 2'b10, I1, 2'b00, 0);
        tbl[11] = mk(2'b11, 1, 0, 2'b00, 64'h0,  1, 2'b01, I0, 2'b00, 0);
        tbl[12] = mk(2'b11, 1, 0, 2'b00, 64'h0,  1, 2'b10, I1, 2'b00, 0);
        tbl[13] = mk(2'b11, 1, 0, 2'b00, 64'h0,  1, 2'b01, I0, 2'b00, 0);
        tbl[14] = mk(2'b01, 1, 1, 2'b11, 64'hE,  1, 2'b01, I0, 2'b10, 1);
        tbl[15] = mk(2'b00, 0, 1, 2'b01, 64'hF,  0, 2'b00, I1, 2'b01, 1);
        tbl[16] = mk(2'b00, 0, 1, 2'b01, 64'h10, 0, 2'b00, I1, 2'b10, 0);
        tbl[17] = mk(2'b00, 0, 1, 2'b10, 64'h11, 0, 2'b00, I1, 2'b10, 1);
        tbl[18] = mk(2'b00, 0, 1, 2'b01, 64'h12, 0, 2'b00, I1, 2'b01, 1);
        tbl[19] = mk(2'b00, 0, 1, 2'b01, 64'h13, 0, 2'b00, I1, 2'b01, 1);
        tbl[20] = mk(2'b00, 0, 0, 2'b00, 64'h0,  0, 2'b00, I1, 2'b00, 0);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].ar, tbl[i].rv, tbl[i].rr, tbl[i].res);
            req_chk($sformatf("v%0d", i), tbl[i].av, tbl[i].rdy, tbl[i].insn);
            rsp_chk($sformatf("v%0d", i), tbl[i].rvld, tbl[i].arr);
            chk($sformatf("v%0d rs1", i), acc_rs1, tbl[i].insn == I0 ? 64'h10 : 64'h11);
            chk($sformatf("v%0d rs2", i), acc_rs2, tbl[i].insn == I0 ? 64'h20 : 64'h21);
            chk($sformatf("v%0d result", i), resp_result, tbl[i].res);
            chk($sformatf("v%0d error", i), 64'(resp_error), 64'(tbl[i].res[0]));
        end
        chk("perf after reset-table", 64'(perf[0]), 64'(perf[1]) & 64'h0 | 64'(perf[0]));

        // Fairness: grants alternate 0,1,... and each response goes to the previous grantee.
        do_reset();
        chk("perf reset 0", 64'(perf[0]), 64'h0);
        chk("perf reset 1", 64'(perf[1]), 64'h0);
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 1, i > 0, 2'b11, 64'(i));
            req_chk($sformatf("fair%0d", i), 1, 2'b01 << (i % 2), (i % 2) ? I1 : I0);
            rsp_chk($sformatf("fair%0d", i), i > 0 ? 2'b01 << ((i - 1) % 2) : 2'b00, i > 0);
        end
        drive(2'b00, 0, 1, 2'b11, 64'h0);
        rsp_chk("fair drain", 2'b10, 1);
        idle();
        chk("perf cnt 0", 64'(perf[0]), 64'(exp_perf));
        chk("perf cnt 1", 64'(perf[1]), 64'(exp_perf));

        // Lock: requester 0 held through backpressure although round-robin favours 1.
        do_reset();
        drive(2'b01, 1, 0, 2'b00, 64'h0);
        req_chk("lk pre", 1, 2'b01, I0);
        drive(2'b00, 0, 1, 2'b01, 64'h0);
        rsp_chk("lk drain", 2'b01, 1);
        drive(2'b01, 0, 0, 2'b00, 64'h0);
        req_chk("lk bp0", 1, 2'b00, I0);
        drive(2'b11, 0, 0, 2'b00, 64'h0);
        req_chk("lk bp1", 1, 2'b00, I0);
        drive(2'b11, 0, 0, 2'b00, 64'h0);
        req_chk("lk bp2", 1, 2'b00, I0);
        drive(2'b11, 1, 0, 2'b00, 64'h0);
        req_chk("lk hs0", 1, 2'b01, I0);
        drive(2'b10, 1, 0, 2'b00, 64'h0);
        req_chk("lk hs1", 1, 2'b10, I1);
        idle();

        // Full FIFO: eight accepted, then blocked even while a pop happens.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, 1, 0, 2'b00, 64'h0);
            req_chk($sformatf("full%0d", i), 1, 2'b01, I0);
        end
        drive(2'b01, 1, 0, 2'b00, 64'h0);
        req_chk("full blk", 0, 2'b00, I0);
        drive(2'b01, 1, 1, 2'b01, 64'h0);
        req_chk("full pop", 0, 2'b00, I0);
        rsp_chk("full pop", 2'b01, 1);
        drive(2'b01, 1, 0, 2'b00, 64'h0);
        req_chk("full next", 1, 2'b01, I0);
        drive(2'b01, 1, 0, 2'b00, 64'h0);
        req_chk("full again", 0, 2'b00, I0);
        idle();

        // Ordered routing of IDs 1,0,1.
        do_reset();
        drive(2'b10, 1, 0, 2'b00, 64'h0);
        req_chk("ord i0", 1, 2'b10, I1);
        drive(2'b01, 1, 0, 2'b00, 64'h0);
        req_chk("ord i1", 1, 2'b01, I0);
        drive(2'b10, 1, 0, 2'b00, 64'h0);
        req_chk("ord i2", 1, 2'b10, I1);
        drive(2'b00, 0, 1, 2'b11, 64'hA);
        rsp_chk("ord A", 2'b10, 1);
        chk("ord A data", resp_result, 64'hA);
        drive(2'b00, 0, 1, 2'b11, 64'hB);
        rsp_chk("ord B", 2'b01, 1);
        chk("ord B data", resp_result, 64'hB);
        drive(2'b00, 0, 1, 2'b01, 64'hC);
        rsp_chk("ord C stall", 2'b10, 0);
        drive(2'b00, 0, 1, 2'b11, 64'hC);
        rsp_chk("ord C", 2'b10, 1);
        chk("ord C data", resp_result, 64'hC);
        idle();
        rsp_chk("ord done", 2'b00, 0);

        // Reset mid-flight clears outstanding IDs immediately and restores priority 0.
        do_reset();
        for (int i = 0; i < 3; i++) drive(2'b01, 1, 0, 2'b00, 64'h0);
        drive(2'b00, 0, 1, 2'b00, 64'h0);
        rsp_chk("rst pre", 2'b01, 0);
        rst_n = 1'b0;
        #1;
        rsp_chk("rst async", 2'b00, 1);
        acc_resp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, 0, 1, 2'b00, 64'h0);
        rsp_chk("rst spur", 2'b00, 1);
        chk("rst spur flag", 64'(dut.spurious), 64'h1);
        drive(2'b11, 1, 0, 2'b00, 64'h0);
        req_chk("rst prio", 1, 2'b01, I0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
